branch_resolution_table: RTL and testbench

In-order branch resolution queue that consumes the branch target calculator's result FIFO. Each branch is allocated at issue with its prediction. The table collects the computed target from the calculator FIFO and the condition outcome from the branch ALU, then presents resolutions in program order to the commit/flush logic. It flags mispredictions and stalls further resolution until the machine flushes.

---
 rtl/branch_resolution_table.sv | 184 ++++++++++++++++++
 tb/tb_branch_resolution_table.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_table.sv
// In-order branch resolution queue: collects computed targets and condition
// outcomes per branch and presents resolutions in program order.
module branch_resolution_table #(
   parameter int unsigned BRTSIZE = 3,
   parameter int unsigned ROBSIZE = 8
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               i_brt_flush,
   input  logic               i_brt_alloc_en,
   input  logic [ROBSIZE-1:0] i_brt_alloc_rob_addr,
   input  logic               i_brt_alloc_pred_taken,
   input  logic [31:0]        i_brt_alloc_pred_target,
   input  logic [31:0]        i_brt_alloc_fallthru,
   input  logic               i_btc_fifo_empty,
   input  logic [31:0]        i_btc_fifo_target_cal,
   input  logic [ROBSIZE-1:0] i_btc_fifo_rob_addr,
   output logic               o_btc_fifo_rd_en,
   input  logic               i_brt_cond_v,
   input  logic [ROBSIZE-1:0] i_brt_cond_rob_addr,
   input  logic               i_brt_cond_taken,
   output logic               o_brt_res_v,
   output logic [ROBSIZE-1:0] o_brt_res_rob_addr,
   output logic               o_brt_res_mispredict,
   output logic [31:0]        o_brt_res_redirect_pc,
   input  logic               i_brt_res_ack,
   output logic               o_brt_full,
   output logic               o_brt_empty
);

   localparam int unsigned DEPTH = 2 ** BRTSIZE;

   typedef enum logic [1:0] {IDLE, PRESENT, WAIT_FLUSH} state_t;

   state_t state, state_nxt;

   logic [BRTSIZE:0]   head, tail;
   logic [BRTSIZE-1:0] head_idx, tail_idx;

   logic [DEPTH-1:0]   ent_v, ent_tgt_v, ent_cond_v, ent_pred_taken, ent_taken;
   logic [ROBSIZE-1:0] ent_rob      [DEPTH];
   logic [31:0]        ent_pred_tgt [DEPTH];
   logic [31:0]        ent_fallthru [DEPTH];
   logic [31:0]        ent_tgt      [DEPTH];

   logic               full, empty, alloc, load, deq;
   logic               tgt_hit, cond_hit, tgt_cap, cond_cap;
   logic [BRTSIZE-1:0] tgt_idx, cond_idx;
   logic               head_ready, mispredict_calc;
   logic [31:0]        redirect_calc;

   assign head_idx = head[BRTSIZE-1:0];
   assign tail_idx = tail[BRTSIZE-1:0];
   assign full     = (head[BRTSIZE] != tail[BRTSIZE]) && (head_idx == tail_idx);
   assign empty    = (head == tail);

   assign o_brt_full       = full;
   assign o_brt_empty      = empty;
   assign o_btc_fifo_rd_en = !i_btc_fifo_empty;
   assign o_brt_res_v      = (state == PRESENT);

   assign alloc    = i_brt_alloc_en && !full && !i_brt_flush;
   assign tgt_cap  = !i_btc_fifo_empty && tgt_hit && !i_brt_flush;
   assign cond_cap = i_brt_cond_v && cond_hit && !i_brt_flush;

   // CAM over registered valid bits only, so an entry allocated this cycle
   // cannot be matched until the next one; lowest index wins.
   always_comb begin
      tgt_hit  = 1'b0;
      tgt_idx  = '0;
      cond_hit = 1'b0;
      cond_idx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!tgt_hit && ent_v[i] && !ent_tgt_v[i] &&
             (ent_rob[i] == i_btc_fifo_rob_addr)) begin
            tgt_hit = 1'b1;
            tgt_idx = BRTSIZE'(i);
         end
         if (!cond_hit && ent_v[i] && !ent_cond_v[i] &&
             (ent_rob[i] == i_brt_cond_rob_addr)) begin
            cond_hit = 1'b1;
            cond_idx = BRTSIZE'(i);
         end
      end
   end

   assign head_ready      = ent_v[head_idx] && ent_tgt_v[head_idx] && ent_cond_v[head_idx];
   assign mispredict_calc = (ent_taken[head_idx] != ent_pred_taken[head_idx]) ||
                            (ent_taken[head_idx] &&
                             (ent_tgt[head_idx] != ent_pred_tgt[head_idx]));
   assign redirect_calc   = ent_taken[head_idx] ? ent_tgt[head_idx] : ent_fallthru[head_idx];

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      deq       = 1'b0;
      case (state)
         IDLE: begin
            if (head_ready) begin
               load      = 1'b1;
               state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            if (i_brt_res_ack) begin
               deq       = 1'b1;
               state_nxt = o_brt_res_mispredict ? WAIT_FLUSH : IDLE;
            end
         end
         WAIT_FLUSH: state_nxt = WAIT_FLUSH;
         default:    state_nxt = IDLE;
      endcase
      if (i_brt_flush) begin
         state_nxt = IDLE;
         load      = 1'b0;
         deq       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_brt_res_rob_addr    <= '0;
         o_brt_res_mispredict  <= 1'b0;
         o_brt_res_redirect_pc <= '0;
      end else if (i_brt_flush) begin
         o_brt_res_rob_addr    <= '0;
         o_brt_res_mispredict  <= 1'b0;
         o_brt_res_redirect_pc <= '0;
      end else if (load) begin
         o_brt_res_rob_addr    <= ent_rob[head_idx];
         o_brt_res_mispredict  <= mispredict_calc;
         o_brt_res_redirect_pc <= redirect_calc;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head <= '0;
         tail <= '0;
      end else if (i_brt_flush) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (alloc) tail <= tail + (BRTSIZE+1)'(1);
         if (deq)   head <= head + (BRTSIZE+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ent_v      <= '0;
         ent_tgt_v  <= '0;
         ent_cond_v <= '0;
      end else if (i_brt_flush) begin
         ent_v <= '0;
      end else begin
         if (alloc) begin
            ent_v[tail_idx]      <= 1'b1;
            ent_tgt_v[tail_idx]  <= 1'b0;
            ent_cond_v[tail_idx] <= 1'b0;
         end
         if (tgt_cap)  ent_tgt_v[tgt_idx]   <= 1'b1;
         if (cond_cap) ent_cond_v[cond_idx] <= 1'b1;
         if (deq)      ent_v[head_idx]      <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc) begin
         ent_rob[tail_idx]        <= i_brt_alloc_rob_addr;
         ent_pred_taken[tail_idx] <= i_brt_alloc_pred_taken;
         ent_pred_tgt[tail_idx]   <= i_brt_alloc_pred_target;
         ent_fallthru[tail_idx]   <= i_brt_alloc_fallthru;
      end
      if (tgt_cap)  ent_tgt[tgt_idx]     <= i_btc_fifo_target_cal;
      if (cond_cap) ent_taken[cond_idx]  <= i_brt_cond_taken;
   end

endmodule

// File: tb/tb_branch_resolution_table.sv
// Directed bench for branch_resolution_table; expected resolutions are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_branch_resolution_table;

   logic        clk;
   logic        rstn;
   logic        brt_flush;
   logic        alloc_en;
   logic [7:0]  alloc_rob;
   logic        alloc_pred_taken;
   logic [31:0] alloc_pred_target;
   logic [31:0] alloc_fallthru;
   logic        fifo_empty;
   logic [31:0] fifo_target;
   logic [7:0]  fifo_rob;
   logic        fifo_rd_en;
   logic        cond_v;
   logic [7:0]  cond_rob;
   logic        cond_taken;
   logic        res_v;
   logic [7:0]  res_rob;
   logic        res_mis;
   logic [31:0] res_pc;
   logic        res_ack;
   logic        full;
   logic        empty;

   branch_resolution_table #(.BRTSIZE(3), .ROBSIZE(8)) dut (
      .clk                    (clk),
      .rstn                   (rstn),
      .i_brt_flush            (brt_flush),
      .i_brt_alloc_en         (alloc_en),
      .i_brt_alloc_rob_addr   (alloc_rob),
      .i_brt_alloc_pred_taken (alloc_pred_taken),
      .i_brt_alloc_pred_target(alloc_pred_target),
      .i_brt_alloc_fallthru   (alloc_fallthru),
      .i_btc_fifo_empty       (fifo_empty),
      .i_btc_fifo_target_cal  (fifo_target),
      .i_btc_fifo_rob_addr    (fifo_rob),
      .o_btc_fifo_rd_en       (fifo_rd_en),
      .i_brt_cond_v           (cond_v),
      .i_brt_cond_rob_addr    (cond_rob),
      .i_brt_cond_taken       (cond_taken),
      .o_brt_res_v            (res_v),
      .o_brt_res_rob_addr     (res_rob),
      .o_brt_res_mispredict   (res_mis),
      .o_brt_res_redirect_pc  (res_pc),
      .i_brt_res_ack          (res_ack),
      .o_brt_full             (full),
      .o_brt_empty            (empty)
   );

   typedef struct packed {
      logic [7:0]  rob;
      logic        mis;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   logic prev_v = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_res(input logic [7:0] rob, input logic mis, input logic [31:0] pc);
      exp_t e;
      e.rob = rob;
      e.mis = mis;
      e.pc  = pc;
      sb.push_back(e);
   endtask

   task automatic alloc(input logic [7:0] rob, input logic pt, input logic [31:0] ptgt,
                        input logic [31:0] ft);
      alloc_en          = 1'b1;
      alloc_rob         = rob;
      alloc_pred_taken  = pt;
      alloc_pred_target = ptgt;
      alloc_fallthru    = ft;
      tick();
      alloc_en = 1'b0;
   endtask

   task automatic fifo(input logic [31:0] tgt, input logic [7:0] rob);
      fifo_empty  = 1'b0;
      fifo_target = tgt;
      fifo_rob    = rob;
      tick();
      fifo_empty = 1'b1;
   endtask

   task automatic cond(input logic [7:0] rob, input logic taken);
      cond_v     = 1'b1;
      cond_rob   = rob;
      cond_taken = taken;
      tick();
      cond_v = 1'b0;
   endtask

   task automatic flush();
      brt_flush = 1'b1;
      tick();
      brt_flush = 1'b0;
   endtask

   task automatic wait_res();
      int n = 0;
      while (!res_v && n < 40) begin
         tick();
         n++;
      end
      if (!res_v) chk("res_timeout", 32'(res_v), 32'd1);
   endtask

   task automatic ack_res(input int hold);
      wait_res();
      repeat (hold) tick();
      res_ack = 1'b1;
      tick();
      res_ack = 1'b0;
   endtask

   task automatic quiet(input string name, input int cycles);
      repeat (cycles) begin
         tick();
         chk(name, 32'(res_v), 32'd0);
      end
   endtask

   // Monitor: pops on each new presentation, then checks the held values every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (res_v) begin
            if (!prev_v) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_res: got rob 0x%0h, expected no resolution", res_rob);
               end else begin
                  cur = sb.pop_front();
               end
            end
            chk("res_rob", 32'(res_rob), 32'(cur.rob));
            chk("res_mispredict", 32'(res_mis), 32'(cur.mis));
            chk("res_redirect", res_pc, cur.pc);
         end
         prev_v = res_v;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; brt_flush = 1'b0; alloc_en = 1'b0; alloc_rob = '0;
      alloc_pred_taken = 1'b0; alloc_pred_target = '0; alloc_fallthru = '0;
      fifo_empty = 1'b1; fifo_target = '0; fifo_rob = '0;
      cond_v = 1'b0; cond_rob = '0; cond_taken = 1'b0; res_ack = 1'b0;

      // Reset state
      repeat (2) tick();
      chk("rst_res_v", 32'(res_v), 32'd0);
      chk("rst_res_rob", 32'(res_rob), 32'd0);
      chk("rst_res_mis", 32'(res_mis), 32'd0);
      chk("rst_res_pc", res_pc, 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_rd_en_idle", 32'(fifo_rd_en), 32'd0);
      fifo_empty = 1'b0;
      #1;
      chk("rst_rd_en_pop", 32'(fifo_rd_en), 32'd1);
      fifo_empty = 1'b1;
      tick();
      rstn = 1'b1;
      tick();

      // Correct taken prediction
      alloc(8'd5, 1'b1, 32'h100, 32'h44);
      chk("alloc_empty", 32'(empty), 32'd0);
      expect_res(8'd5, 1'b0, 32'h100);
      fifo(32'h100, 8'd5);
      cond(8'd5, 1'b1);
      ack_res(0);
      chk("ack_empty", 32'(empty), 32'd1);

      // Target mismatch, then stall in WAIT_FLUSH with a ready entry behind
      alloc(8'd5, 1'b1, 32'h100, 32'h44);
      alloc(8'd6, 1'b0, 32'h0, 32'h48);
      expect_res(8'd5, 1'b1, 32'h200);
      fifo(32'h200, 8'd5);
      cond(8'd5, 1'b1);
      fifo(32'h60, 8'd6);
      cond(8'd6, 1'b0);
      ack_res(0);
      quiet("wait_flush_res_v", 6);
      chk("wait_flush_empty", 32'(empty), 32'd0);
      flush();
      chk("flush_empty", 32'(empty), 32'd1);
      chk("flush_res_pc", res_pc, 32'd0);

      // Direction mispredict
      alloc(8'd7, 1'b1, 32'h100, 32'h44);
      expect_res(8'd7, 1'b1, 32'h44);
      fifo(32'h100, 8'd7);
      cond(8'd7, 1'b0);
      ack_res(0);
      quiet("dir_mis_stall", 2);
      flush();

      // Fill, drop when full, reverse-order capture
      for (int i = 1; i <= 8; i++)
         alloc(8'(i), (i % 2) == 1, 32'h1000 + 32'(i) * 16, 32'h2000 + 32'(i) * 4);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_empty", 32'(empty), 32'd0);
      alloc(8'd9, 1'b1, 32'h9000, 32'h9004);
      chk("drop_full", 32'(full), 32'd1);
      for (int i = 1; i <= 8; i++)
         if (i % 2 == 1) expect_res(8'(i), 1'b0, 32'h1000 + 32'(i) * 16);
         else            expect_res(8'(i), 1'b0, 32'h2000 + 32'(i) * 4);
      for (int i = 8; i >= 1; i--) begin
         fifo(32'h1000 + 32'(i) * 16, 8'(i));
         cond(8'(i), (i % 2) == 1);
      end
      for (int i = 0; i < 8; i++) ack_res(0);
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_full", 32'(full), 32'd0);

      // Wrapped pointers
      for (int i = 9; i <= 12; i++) begin
         alloc(8'(i), 1'b1, 32'h3000 + 32'(i) * 8, 32'h3400 + 32'(i) * 4);
         expect_res(8'(i), 1'b0, 32'h3000 + 32'(i) * 8);
      end
      fifo(32'h3000 + 32'd10 * 8, 8'd10);
      fifo(32'h3000 + 32'd9 * 8, 8'd9);
      cond(8'd12, 1'b1);
      cond(8'd9, 1'b1);
      fifo(32'h3000 + 32'd12 * 8, 8'd12);
      fifo(32'h3000 + 32'd11 * 8, 8'd11);
      cond(8'd11, 1'b1);
      cond(8'd10, 1'b1);
      for (int i = 0; i < 4; i++) ack_res(0);
      chk("wrap_empty", 32'(empty), 32'd1);

      // Flush with pending entries, then stale FIFO data
      alloc(8'd1, 1'b1, 32'h300, 32'h10);
      alloc(8'd2, 1'b1, 32'h300, 32'h20);
      alloc(8'd3, 1'b1, 32'h300, 32'h30);
      flush();
      fifo_empty = 1'b0; fifo_target = 32'h300; fifo_rob = 8'd3;
      #1;
      chk("stale_rd_en", 32'(fifo_rd_en), 32'd1);
      tick();
      fifo_empty = 1'b1;
      chk("stale_empty", 32'(empty), 32'd1);
      cond(8'd3, 1'b1);
      alloc(8'd3, 1'b0, 32'h0, 32'h50);
      cond(8'd3, 1'b0);
      quiet("no_stale_target", 4);
      expect_res(8'd3, 1'b0, 32'h50);
      fifo(32'h300, 8'd3);
      ack_res(0);

      // Hold in PRESENT for 5 cycles, ack on the 6th
      alloc(8'd4, 1'b1, 32'h400, 32'h60);
      expect_res(8'd4, 1'b0, 32'h400);
      fifo(32'h400, 8'd4);
      cond(8'd4, 1'b1);
      ack_res(5);
      chk("post_ack_res_v", 32'(res_v), 32'd0);

      // Pop in the same cycle as allocation is not matched
      alloc_en = 1'b1; alloc_rob = 8'd11; alloc_pred_taken = 1'b1;
      alloc_pred_target = 32'h500; alloc_fallthru = 32'h70;
      fifo_empty = 1'b0; fifo_target = 32'h500; fifo_rob = 8'd11;
      tick();
      alloc_en = 1'b0; fifo_empty = 1'b1;
      cond(8'd11, 1'b1);
      quiet("same_cycle_no_match", 4);
      expect_res(8'd11, 1'b0, 32'h500);
      fifo(32'h500, 8'd11);
      ack_res(0);

      // Asynchronous reset in PRESENT
      alloc(8'd12, 1'b0, 32'h0, 32'h80);
      expect_res(8'd12, 1'b0, 32'h80);
      fifo(32'h600, 8'd12);
      cond(8'd12, 1'b0);
      wait_res();
      #6;
      rstn = 1'b0;
      #1;
      chk("async_rst_res_v", 32'(res_v), 32'd0);
      chk("async_rst_empty", 32'(empty), 32'd1);
      tick();
      rstn = 1'b1;
      tick();

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
